axi_mem_responder: RTL and testbench



---
 rtl/axi_mem_responder_if.sv | 49 ++++
 rtl/axi_mem_responder.sv | 187 ++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_responder_if.sv
// ============================================================================
// Module   : axi_mem_responder_if
// Purpose  : AXI-subset AW/W/B/AR/R bundle between memory arbiter and responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface axi_mem_responder_if #(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32
);
    logic                  AWVALID;
    logic                  AWREADY;
    logic [3:0]            AWID;
    logic [3:0]            AWLEN;
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic                  WVALID;
    logic                  WREADY;
    logic                  WLAST;
    logic [3:0]            WID;
    logic [DATA_WIDTH-1:0] WDATA;
    logic                  BVALID;
    logic                  BREADY;
    logic [3:0]            BID;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [3:0]            ARID;
    logic [3:0]            ARLEN;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  RVALID;
    logic                  RREADY;
    logic                  RLAST;
    logic [3:0]            RID;
    logic [DATA_WIDTH-1:0] RDATA;

    modport master (
        output AWVALID, AWID, AWLEN, AWADDR, WVALID, WLAST, WID, WDATA, BREADY,
               ARVALID, ARID, ARLEN, ARADDR, RREADY,
        input  AWREADY, WREADY, BVALID, BID, ARREADY, RVALID, RLAST, RID, RDATA
    );

    modport slave (
        input  AWVALID, AWID, AWLEN, AWADDR, WVALID, WLAST, WID, WDATA, BREADY,
               ARVALID, ARID, ARLEN, ARADDR, RREADY,
        output AWREADY, WREADY, BVALID, BID, ARREADY, RVALID, RLAST, RID, RDATA
    );
endinterface

`default_nettype wire

// File: rtl/axi_mem_responder.sv
// ============================================================================
// Module   : axi_mem_responder
// Purpose  : AXI-subset memory slave with independent read and write burst FSMs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axi_mem_responder #(
    parameter int ADDR_WIDTH   = 26,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH_LOG2   = 16,
    parameter int READ_LATENCY = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    axi_mem_responder_if.slave  axi,
    output logic                proto_err
);

    localparam logic [3:0] c_WAIT_INIT = (READ_LATENCY > 0) ? 4'(READ_LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_WAIT  = 2'd1,
        R_BURST = 2'd2
    } rstate_t;

    logic [DATA_WIDTH-1:0] r_mem [2**DEPTH_LOG2];

    wstate_t               r_wstate;
    wstate_t               w_wstate_nxt;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [3:0]            r_wlen;
    logic [3:0]            r_bid;
    logic                  r_proto_err;

    rstate_t               r_rstate;
    rstate_t               w_rstate_nxt;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [ADDR_WIDTH-1:0] w_raddr_nxt;
    logic [3:0]            r_rlen;
    logic [3:0]            r_wait;
    logic [3:0]            r_rid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] w_rd_word;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_unused;

    assign w_unused = ^axi.WID;

    // Every handshake-facing output is forced low while rst is held.
    assign axi.AWREADY = !rst && (r_wstate == W_IDLE);
    assign axi.WREADY  = !rst && (r_wstate == W_DATA);
    assign axi.BVALID  = !rst && (r_wstate == W_RESP);
    assign axi.BID     = axi.BVALID ? r_bid : 4'd0;
    assign axi.ARREADY = !rst && (r_rstate == R_IDLE);
    assign axi.RVALID  = !rst && (r_rstate == R_BURST);
    assign axi.RLAST   = axi.RVALID && (r_rlen == 4'd0);
    assign axi.RID     = axi.RVALID ? r_rid : 4'd0;
    assign axi.RDATA   = axi.RVALID ? r_rdata : '0;
    assign proto_err   = !rst && r_proto_err;

    assign w_aw_hs = axi.AWVALID && axi.AWREADY;
    assign w_w_hs  = axi.WVALID  && axi.WREADY;
    assign w_ar_hs = axi.ARVALID && axi.ARREADY;
    assign w_r_hs  = axi.RVALID  && axi.RREADY;

    // ---------------- write channel ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
            W_DATA:  if (w_w_hs && (r_wlen == 4'd0)) w_wstate_nxt = W_RESP;
            W_RESP:  if (axi.BREADY) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_waddr     <= '0;
            r_wlen      <= 4'd0;
            r_bid       <= 4'd0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_waddr <= axi.AWADDR;
                r_wlen  <= axi.AWLEN;
                r_bid   <= axi.AWID;
            end
            if (w_w_hs) begin
                r_waddr <= r_waddr + 1'b1;
                r_wlen  <= r_wlen - 4'd1;
                // The beat count ends the burst; WLAST is only audited.
                if ((r_wlen == 4'd0) != axi.WLAST) begin
                    r_proto_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_w_hs) begin
            r_mem[r_waddr[DEPTH_LOG2-1:0]] <= axi.WDATA;
        end
    end

    // ---------------- read channel ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = (READ_LATENCY == 0) ? R_BURST : R_WAIT;
            R_WAIT:  if (r_wait == 4'd0) w_rstate_nxt = R_BURST;
            R_BURST: if (w_r_hs && (r_rlen == 4'd0)) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // The word for the next presented beat is fetched a cycle early; a write
    // to that same index in this cycle is forwarded so it is not lost.
    always_comb begin
        w_raddr_nxt = r_raddr;
        if (w_ar_hs) begin
            w_raddr_nxt = axi.ARADDR;
        end else if (w_r_hs) begin
            w_raddr_nxt = r_raddr + 1'b1;
        end
        w_rd_word = r_mem[w_raddr_nxt[DEPTH_LOG2-1:0]];
        if (w_w_hs && (r_waddr[DEPTH_LOG2-1:0] == w_raddr_nxt[DEPTH_LOG2-1:0])) begin
            w_rd_word = axi.WDATA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_raddr <= '0;
            r_rlen  <= 4'd0;
            r_wait  <= 4'd0;
            r_rid   <= 4'd0;
            r_rdata <= '0;
        end else begin
            r_raddr <= w_raddr_nxt;
            if (w_ar_hs) begin
                r_rlen <= axi.ARLEN;
                r_rid  <= axi.ARID;
                r_wait <= c_WAIT_INIT;
            end else if ((r_rstate == R_WAIT) && (r_wait != 4'd0)) begin
                r_wait <= r_wait - 4'd1;
            end
            if (w_r_hs) begin
                r_rlen <= r_rlen - 4'd1;
            end
            if (!((r_rstate == R_BURST) && !axi.RREADY)) begin
                r_rdata <= w_rd_word;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_mem_responder.sv
// ============================================================================
// Module   : tb_axi_mem_responder
// Purpose  : Directed scoreboard bench for axi_mem_responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_axi_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic proto_err;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] d;
        logic        last;
        logic [3:0]  id;
    } rexp_t;

    rexp_t       r_q[$];
    logic [3:0]  b_q[$];
    logic [31:0] model [int];

    axi_mem_responder_if #(.ADDR_WIDTH(26), .DATA_WIDTH(32)) bus ();

    axi_mem_responder #(
        .ADDR_WIDTH  (26),
        .DATA_WIDTH  (32),
        .DEPTH_LOG2  (16),
        .READ_LATENCY(2)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .axi      (bus),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: R beats compared against queue front every valid
    // cycle (so stalls must hold), popped on handshake; B popped on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.RVALID) begin
                if (r_q.size() == 0) begin
                    check("r_unexpected_beat", 64'd1, 64'd0);
                end else begin
                    check("r_beat", {27'd0, bus.RID, bus.RLAST, bus.RDATA},
                          {27'd0, r_q[0].id, r_q[0].last, r_q[0].d});
                    if (bus.RREADY) void'(r_q.pop_front());
                end
            end
            if (bus.BVALID && bus.BREADY) begin
                if (b_q.size() == 0) begin
                    check("b_unexpected", 64'd1, 64'd0);
                end else begin
                    check("b_id", {60'd0, bus.BID}, {60'd0, b_q.pop_front()});
                end
            end
        end
    end

    task automatic write_burst(input logic [3:0] id, input logic [25:0] addr, input logic [3:0] len,
                               input int last_at, input logic [31:0] base, input logic [31:0] inc);
        int guard;
        logic [25:0] a;
        step();
        bus.AWVALID = 1'b1; bus.AWID = id; bus.AWLEN = len; bus.AWADDR = addr;
        guard = 0;
        @(negedge clk);
        while (!bus.AWREADY && guard < 20) begin @(negedge clk); guard++; end
        check("aw_handshake", {63'd0, bus.AWREADY}, 64'd1);
        step();
        bus.AWVALID = 1'b0;
        b_q.push_back(id);
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + 26'(i);
            bus.WVALID = 1'b1;
            bus.WID    = id;
            bus.WDATA  = base + inc * 32'(i);
            bus.WLAST  = (i == last_at);
            model[int'(a[15:0])] = bus.WDATA;
            guard = 0;
            @(negedge clk);
            while (!bus.WREADY && guard < 20) begin @(negedge clk); guard++; end
            check("w_handshake", {63'd0, bus.WREADY}, 64'd1);
            step();
        end
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        @(negedge clk);
        check("b_valid_after_last", {63'd0, bus.BVALID}, 64'd1);
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [25:0] addr, input logic [3:0] len,
                              input bit stall);
        int guard;
        int lat;
        int accepted;
        int pat;
        logic [25:0] a;
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + 26'(i);
            r_q.push_back('{d: model[int'(a[15:0])], last: (i == int'(len)), id: id});
        end
        step();
        bus.RREADY = 1'b1;
        bus.ARVALID = 1'b1; bus.ARID = id; bus.ARLEN = len; bus.ARADDR = addr;
        guard = 0;
        @(negedge clk);
        while (!bus.ARREADY && guard < 20) begin @(negedge clk); guard++; end
        check("ar_handshake", {63'd0, bus.ARREADY}, 64'd1);
        step();
        bus.ARVALID = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.RVALID && lat < 20);
        check("r_first_latency", 64'(lat), 64'd3);
        accepted = 0;
        pat = 0;
        guard = 0;
        while (accepted <= int'(len) && guard < 100) begin
            if (bus.RVALID && bus.RREADY) accepted++;
            step();
            pat++;
            bus.RREADY = stall ? (pat % 3 == 0) : 1'b1;
            @(negedge clk);
            guard++;
        end
        check("r_beats_accepted", 64'(accepted), 64'(int'(len) + 1));
        bus.RREADY = 1'b1;
    endtask

    initial begin
        bus.AWVALID = 1'b0; bus.AWID = 4'd0; bus.AWLEN = 4'd0; bus.AWADDR = '0;
        bus.WVALID  = 1'b0; bus.WLAST = 1'b0; bus.WID = 4'd0; bus.WDATA = '0;
        bus.BREADY  = 1'b1;
        bus.ARVALID = 1'b0; bus.ARID = 4'd0; bus.ARLEN = 4'd0; bus.ARADDR = '0;
        bus.RREADY  = 1'b1;
        rst = 1'b1;

        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", {bus.AWREADY, bus.ARREADY, bus.WREADY, bus.BVALID, bus.RVALID,
                                bus.RLAST, proto_err, bus.BID, bus.RID, bus.RDATA}, 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {59'd0, bus.AWREADY, bus.ARREADY, bus.WREADY, bus.BVALID,
                                    bus.RVALID}, 64'b11000);

        write_burst(4'd3, 26'h100, 4'd3, 3, 32'hA0, 32'h1);
        check("proto_err_clean", {63'd0, proto_err}, 64'd0);

        read_burst(4'd5, 26'h100, 4'd3, 1'b0);
        read_burst(4'd6, 26'h100, 4'd3, 1'b1);

        write_burst(4'd1, 26'hFFFF, 4'd1, 1, 32'h11, 32'h11);
        read_burst(4'd2, 26'hFFFF, 4'd1, 1'b0);
        read_burst(4'd4, 26'h0, 4'd0, 1'b0);
        check("wrap_model_idx0", {32'd0, model[0]}, 64'h22);

        write_burst(4'd7, 26'h200, 4'd2, 1, 32'hB0, 32'h1);
        check("proto_err_set", {63'd0, proto_err}, 64'd1);
        step(); step(); step();
        @(negedge clk);
        check("proto_err_sticky", {63'd0, proto_err}, 64'd1);
        read_burst(4'd8, 26'h200, 4'd2, 1'b0);

        // Abandon a stalled read burst with reset.
        for (int i = 0; i < 4; i++) r_q.push_back('{d: 32'hA0 + 32'(i), last: (i == 3), id: 4'd9});
        step();
        bus.RREADY = 1'b0;
        bus.ARVALID = 1'b1; bus.ARID = 4'd9; bus.ARLEN = 4'd3; bus.ARADDR = 26'h100;
        @(negedge clk);
        check("ar_handshake_rst", {63'd0, bus.ARREADY}, 64'd1);
        step();
        bus.ARVALID = 1'b0;
        begin
            int guard;
            guard = 0;
            @(negedge clk);
            while (!bus.RVALID && guard < 20) begin @(negedge clk); guard++; end
            check("stalled_rvalid", {63'd0, bus.RVALID}, 64'd1);
        end
        step();
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_burst", {62'd0, bus.RVALID, proto_err}, 64'd0);
        step();
        rst = 1'b0;
        r_q.delete();
        @(negedge clk);
        check("post_rst_state", {61'd0, bus.RVALID, bus.ARREADY, proto_err}, 64'b010);
        read_burst(4'd10, 26'h100, 4'd3, 1'b0);

        step(); step();
        check("queues_drained", 64'(r_q.size() + b_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
